dmem_mmio: RTL and testbench
============================

# dmem_mmio

Data-side memory stage sitting directly downstream of the single-cycle RISC-V core. It consumes the core's store/load request (ALU result as address, store data, size code, write strobe) and returns a size-extended load value in the same cycle. Besides word-addressed RAM it provides a small MMIO window: a byte TX FIFO with a valid/ready drain port, a status/clear register and a free-running 64-bit cycle counter.

## Interface
Parameters:
- MEM_WORDS, 1024, RAM depth in 32-bit words (power of two)
- FIFO_DEPTH, 8, TX FIFO entries (power of two, ≥2)
- MMIO_BASE, 32'hFFFF_0000, base of the MMIO window (16-byte aligned)

Ports:
- clk  in  1  clock; all state on rising edge
- reset  in  1  synchronous, active-high
- addr  in  32  byte address (core ALU result)
- memwrite  in  1  store strobe
- memsize  in  3  funct3 size code
- writedata  in  32  store data, low-aligned
- readdata  out  32  extended load value, combinational
- tx_data  out  8  FIFO head byte
- tx_valid  out  1  FIFO non-empty
- tx_ready  in  1  consumer accepts head
- misalign  out  1  sticky misalignment flag

## Operation
- memsize: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU. Stores use 000/001/010 only. Codes 011/110/111 (and 100/101 with memwrite): readdata 0, write suppressed.
- RAM (addr < MMIO_BASE): word index addr[log2(MEM_WORDS)+1:2], wraps modulo MEM_WORDS. Byte lane from addr[1:0], half lane from addr[1]. Loads sign- or zero-extend per code. Stores write only the addressed lanes. RAM contents are not reset.
- MMIO (offsets from MMIO_BASE, word accesses only; other sizes read 0 / write ignored):
  - +0x0 TX: write pushes writedata[7:0]. If full, byte dropped and overflow sticky set. Read returns 0.
  - +0x4 STATUS: read {28'b0, misalign, overflow, full, empty}. Writing 1 to bit2/bit3 clears that sticky bit.
  - +0x8 / +0xC: cycle counter low / high word. Read-only; writes ignored.
  - +0x10 and above within the MMIO page: read 0, write ignored.
- FIFO: tx_valid = !empty, tx_data = head. Pop when tx_valid & tx_ready. A push and pop in the same cycle while full: both take effect, no overflow.
- Counter increments by 1 every cycle, wraps at 2^64. Reads return the pre-increment value. There is no hi/lo latch: software re-reads the high word to detect carry.

## Timing
- Load: readdata valid in the same cycle as addr/memsize (zero-latency combinational path).
- Store, FIFO push/pop, sticky set/clear: take effect on the next rising edge.
- First byte is visible on tx_valid one cycle after the TX store.
- Sticky set and clear in the same cycle: set wins.
- Reset (any time, including mid-drain): FIFO emptied, tx_valid 0, tx_data 0, counter 0, misalign 0, overflow 0. readdata from RAM is unaffected.

## Configuration
- DMEM_MISALIGN_CHECK_EN defined:
  - Half access with addr[0]=1, or word access with addr[1:0]≠0, suppresses the write, drives readdata 0 and sets misalign.
  - Misaligned MMIO accesses are treated the same way.
- Undefined:
  - Offending low address bits are ignored, i.e. the access is forced to natural alignment.
  - misalign is tied 0 and STATUS bit3 reads 0.

## Structure
- Package dmem_pkg: memsize encodings, MMIO offsets, STATUS bit positions.
- One sub-module, tx_fifo: parameterised synchronous FIFO with push/pop/full/empty.
- RAM, decode, extension and the counter live in dmem_mmio.

## Test plan
- SW 0xDEADBEEF @0x100; LB @0x103 -> 0xFFFFFFDE; LBU @0x103 -> 0x000000DE; LH @0x102 -> 0xFFFFDEAD; LHU @0x100 -> 0x0000BEEF.
- SB 0x55 @0x101 over 0xDEADBEEF -> LW @0x100 returns 0xDEAD55EF. Store @addr MEM_WORDS*4 aliases to word 0.
- Push 9 bytes (0x41..0x49), tx_ready=0:
  - STATUS = 0x6 (full, overflow).
  - Drain yields 0x41..0x48, then empty.
  - Write STATUS 0x4 -> STATUS 0x1.
- FIFO full, tx_ready=1, push 0x5A in the same cycle -> no overflow, 0x5A is the last byte drained.
- Counter: read low, wait 10 cycles, read low -> difference 11 (accounts for the second read's cycle). Reset mid-run -> next read 0.
- With DMEM_MISALIGN_CHECK_EN: SW @0x102 -> memory unchanged, misalign=1, STATUS bit3=1. Without the macro: the same store writes word 0x100.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory / MMIO stage: funct3 size codes,
// MMIO register word offsets, STATUS bit positions and the load extender.
package dmem_pkg;

  typedef enum logic [2:0] {
    MS_B  = 3'b000,
    MS_H  = 3'b001,
    MS_W  = 3'b010,
    MS_BU = 3'b100,
    MS_HU = 3'b101
  } memsize_e;

  // MMIO register selected by addr[3:2] inside the first 16 bytes of the window
  typedef enum logic [1:0] {
    REG_TX     = 2'd0,
    REG_STATUS = 2'd1,
    REG_CNT_LO = 2'd2,
    REG_CNT_HI = 2'd3
  } mmio_reg_e;

  localparam int ST_EMPTY    = 0;
  localparam int ST_FULL     = 1;
  localparam int ST_OVERFLOW = 2;
  localparam int ST_MISALIGN = 3;

  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  lane,
                                              input logic [2:0]  size);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[8*lane +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      MS_B:    return {{24{b[7]}}, b};
      MS_BU:   return {24'b0, b};
      MS_H:    return {{16{h[15]}}, h};
      MS_HU:   return {16'b0, h};
      MS_W:    return word;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_mmio_tx_fifo.sv
// Synchronous FIFO with wrap-bit pointers; a push while full is accepted
// only when a pop frees a slot in the same cycle.
module tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic             push_en, pop_en;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop_en  = pop_i && !empty_o;
  assign push_en = push_i && (!full_o || pop_en);

  always_comb begin
    wr_d = wr_q + {{AW{1'b0}}, push_en};
    rd_d = rd_q + {{AW{1'b0}}, pop_en};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_q[AW-1:0]] <= data_i;
  end

  // Gate the head so a drained or freshly reset FIFO presents zero
  assign head_o = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

endmodule

// File: rtl/dmem_mmio.sv
// Data memory stage: word RAM with byte/half lanes plus an MMIO window
// (TX FIFO, STATUS, 64-bit cycle counter). DMEM_MISALIGN_CHECK_EN enables traps.
module dmem_mmio
  import dmem_pkg::*;
#(
  parameter int          MEM_WORDS  = 1024,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        memwrite,
  input  logic [2:0]  memsize,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        misalign
);
  localparam int IDX_W = $clog2(MEM_WORDS);

  logic [31:0]      mem [MEM_WORDS];
  logic [IDX_W-1:0] ram_idx;
  logic [31:0]      ram_word, mmio_word, status_word, ram_wdata;
  logic [3:0]       ram_be;
  logic [1:0]       lane;
  logic [1:0]       reg_sel;
  logic             is_half, is_word, size_ok, mis_block;
  logic             is_mmio, mmio_hit, ram_ok, mmio_ok, ram_we;
  logic             tx_push, tx_pop, st_wr, fifo_full, fifo_empty;
  logic             overflow_q, overflow_d;
  logic             misalign_bit;
  logic [63:0]      cnt_q, cnt_d;

  always_comb begin
    is_half = (memsize == MS_H) || (memsize == MS_HU);
    is_word = (memsize == MS_W);
    if (memwrite) size_ok = (memsize == MS_B) || (memsize == MS_H) || (memsize == MS_W);
    else          size_ok = (memsize == MS_B) || is_half || is_word || (memsize == MS_BU);
`ifdef DMEM_MISALIGN_CHECK_EN
    mis_block = size_ok && ((is_half && addr[0]) || (is_word && (addr[1:0] != 2'b00)));
    lane      = addr[1:0];
`else
    mis_block = 1'b0;
    // Drop offending low bits so the access lands on its natural boundary
    lane      = is_word ? 2'b00 : (is_half ? {addr[1], 1'b0} : addr[1:0]);
`endif
  end

  assign is_mmio  = (addr >= MMIO_BASE);
  assign mmio_hit = (addr[31:4] - MMIO_BASE[31:4]) == 28'd0;
  assign reg_sel  = addr[3:2];
  assign ram_idx  = addr[IDX_W+1:2];
  assign ram_ok   = !is_mmio && size_ok && !mis_block;
  assign mmio_ok  = is_mmio && mmio_hit && is_word && size_ok && !mis_block;
  assign ram_word = mem[ram_idx];

  assign status_word = {28'b0, misalign_bit, overflow_q, fifo_full, fifo_empty};

  always_comb begin
    mmio_word = '0;
    case (reg_sel)
      REG_STATUS: mmio_word = status_word;
      REG_CNT_LO: mmio_word = cnt_q[31:0];
      REG_CNT_HI: mmio_word = cnt_q[63:32];
      default:    mmio_word = '0;
    endcase
  end

  always_comb begin
    readdata = '0;
    if (ram_ok)       readdata = load_extend(ram_word, lane, memsize);
    else if (mmio_ok) readdata = mmio_word;
  end

  always_comb begin
    ram_be    = 4'b0000;
    ram_wdata = writedata;
    case (memsize)
      MS_B: begin
        ram_be    = 4'b0001 << lane;
        ram_wdata = {4{writedata[7:0]}};
      end
      MS_H: begin
        ram_be    = lane[1] ? 4'b1100 : 4'b0011;
        ram_wdata = {2{writedata[15:0]}};
      end
      MS_W:    ram_be = 4'b1111;
      default: ram_be = 4'b0000;
    endcase
  end

  assign ram_we = ram_ok && memwrite;

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (ram_be[b]) mem[ram_idx][8*b +: 8] <= ram_wdata[8*b +: 8];
      end
    end
  end

  assign tx_push = mmio_ok && memwrite && (reg_sel == REG_TX);
  assign st_wr   = mmio_ok && memwrite && (reg_sel == REG_STATUS);
  assign tx_pop  = tx_valid && tx_ready;

  tx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (tx_push),
    .data_i  (writedata[7:0]),
    .pop_i   (tx_pop),
    .head_o  (tx_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign tx_valid = !fifo_empty;

  // Set has priority over a same-cycle write-1-to-clear
  always_comb begin
    overflow_d = overflow_q;
    if (st_wr && writedata[ST_OVERFLOW]) overflow_d = 1'b0;
    if (tx_push && fifo_full && !tx_pop) overflow_d = 1'b1;
    cnt_d = cnt_q + 64'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      overflow_q <= overflow_d;
      cnt_q      <= cnt_d;
    end
  end

`ifdef DMEM_MISALIGN_CHECK_EN
  logic misalign_q, misalign_d;

  always_comb begin
    misalign_d = misalign_q;
    if (st_wr && writedata[ST_MISALIGN]) misalign_d = 1'b0;
    if (mis_block) misalign_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) misalign_q <= 1'b0;
    else       misalign_q <= misalign_d;
  end

  assign misalign_bit = misalign_q;
`else
  assign misalign_bit = 1'b0;
`endif

  assign misalign = misalign_bit;

endmodule

// File: tb/tb_dmem_mmio.sv
// Directed, table-driven bench for dmem_mmio plus hand-written FIFO/counter sequences.
module tb_dmem_mmio;

`ifdef DMEM_MISALIGN_CHECK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  localparam logic [2:0] C_B = 3'b000, C_H = 3'b001, C_W = 3'b010,
                         C_BU = 3'b100, C_HU = 3'b101;
  localparam logic [31:0] A_TX  = 32'hFFFF_0000, A_ST = 32'hFFFF_0004,
                          A_CLO = 32'hFFFF_0008, A_CHI = 32'hFFFF_000C;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] addr = '0;
  logic        memwrite = 1'b0;
  logic [2:0]  memsize = C_W;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        misalign;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_mmio dut (
    .clk       (clk),
    .reset     (reset),
    .addr      (addr),
    .memwrite  (memwrite),
    .memsize   (memsize),
    .writedata (writedata),
    .readdata  (readdata),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .misalign  (misalign)
  );

  typedef struct {
    logic        we;
    logic [31:0] a;
    logic [2:0]  sz;
    logic [31:0] wd;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic we, input logic [31:0] a, input logic [2:0] sz,
                              input logic [31:0] wd, input logic chk, input logic [31:0] exp);
    vec_t v;
    v.we = we; v.a = a; v.sz = sz; v.wd = wd; v.chk = chk; v.exp = exp;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One bus cycle: drive after a rising edge, sample readdata at the falling edge
  task automatic access(input logic we, input logic [31:0] a, input logic [2:0] sz,
                        input logic [31:0] wd, output logic [31:0] rd);
    memwrite = we; addr = a; memsize = sz; writedata = wd;
    @(negedge clk);
    rd = readdata;
    $display("txn we=%0d addr=0x%08h size=%0d wdata=0x%08h rdata=0x%08h", we, a, sz, wd, rd);
    @(posedge clk);
    #1;
    memwrite = 1'b0; addr = '0; memsize = C_W; writedata = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain_check(input string name, input logic [7:0] exp);
    @(negedge clk);
    check({name, "_valid"}, {31'b0, tx_valid}, 32'd1);
    check({name, "_data"}, {24'b0, tx_data}, {24'b0, exp});
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, c1, c2;

    vecs.push_back(mk(1, 32'h100, C_W,  32'hDEADBEEF, 0, 0));
    vecs.push_back(mk(0, 32'h103, C_B,  0, 1, 32'hFFFFFFDE));
    vecs.push_back(mk(0, 32'h103, C_BU, 0, 1, 32'h000000DE));
    vecs.push_back(mk(0, 32'h102, C_H,  0, 1, 32'hFFFFDEAD));
    vecs.push_back(mk(0, 32'h100, C_HU, 0, 1, 32'h0000BEEF));
    vecs.push_back(mk(0, 32'h100, C_W,  0, 1, 32'hDEADBEEF));
    vecs.push_back(mk(0, 32'h100, C_B,  0, 1, 32'hFFFFFFEF));
    vecs.push_back(mk(1, 32'h101, C_B,  32'h00000055, 0, 0));
    vecs.push_back(mk(0, 32'h100, C_W,  0, 1, 32'hDEAD55EF));
    vecs.push_back(mk(1, 32'h104, C_W,  32'h00000000, 0, 0));
    vecs.push_back(mk(1, 32'h106, C_H,  32'hABCD1234, 0, 0));
    vecs.push_back(mk(0, 32'h104, C_W,  0, 1, 32'h12340000));
    vecs.push_back(mk(0, 32'h106, C_H,  0, 1, 32'h00001234));
    vecs.push_back(mk(0, 32'h107, C_BU, 0, 1, 32'h00000012));
    vecs.push_back(mk(1, 32'h1000, C_W, 32'hCAFEF00D, 0, 0));
    vecs.push_back(mk(0, 32'h0,   C_W,  0, 1, 32'hCAFEF00D));
    vecs.push_back(mk(0, 32'h100, 3'b011, 0, 1, 32'h0));
    vecs.push_back(mk(0, 32'h100, 3'b111, 0, 1, 32'h0));
    vecs.push_back(mk(1, 32'h100, C_BU, 32'hFFFFFFFF, 1, 32'h0));
    vecs.push_back(mk(0, 32'h100, C_W,  0, 1, 32'hDEAD55EF));
    vecs.push_back(mk(0, A_ST,    C_B,  0, 1, 32'h0));
    vecs.push_back(mk(0, A_ST,    C_W,  0, 1, 32'h1));
    vecs.push_back(mk(0, 32'hFFFF_0010, C_W, 0, 1, 32'h0));
    vecs.push_back(mk(0, A_TX,    C_W,  0, 1, 32'h0));
    vecs.push_back(mk(1, A_CHI,   C_W,  32'h12345678, 0, 0));
    vecs.push_back(mk(0, A_CHI,   C_W,  0, 1, 32'h0));
    vecs.push_back(mk(0, 32'h101, C_W,  0, 1, MIS_EN ? 32'h0 : 32'hDEAD55EF));
    vecs.push_back(mk(1, 32'h102, C_W,  32'h11223344, 0, 0));
    vecs.push_back(mk(0, 32'h100, C_W,  0, 1, MIS_EN ? 32'hDEAD55EF : 32'h11223344));
    vecs.push_back(mk(0, A_ST,    C_W,  0, 1, MIS_EN ? 32'h9 : 32'h1));
    vecs.push_back(mk(0, 32'h103, C_H,  0, 1, MIS_EN ? 32'h0 : (MIS_EN ? 32'h0 : 32'h00001122)));

    // Reset state
    idle(2);
    reset = 1'b0;
    check("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
    check("rst_tx_data", {24'b0, tx_data}, 32'd0);
    check("rst_misalign", {31'b0, misalign}, 32'd0);
    access(0, A_CLO, C_W, 0, rd);
    check("rst_cnt_lo", rd, 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      access(vecs[i].we, vecs[i].a, vecs[i].sz, vecs[i].wd, rd);
      if (vecs[i].chk) check($sformatf("vec%0d", i), rd, vecs[i].exp);
    end

    // Sticky misalign and its write-1-to-clear
    check("misalign_flag", {31'b0, misalign}, {31'b0, MIS_EN});
    access(1, A_ST, C_W, 32'h8, rd);
    check("misalign_clr", {31'b0, misalign}, 32'd0);
    access(0, A_ST, C_W, 0, rd);
    check("status_after_mclr", rd, 32'h1);

    // Overflow: nine pushes into an eight-deep FIFO
    for (int i = 0; i < 9; i++) begin
      access(1, A_TX, C_W, 32'h41 + i, rd);
      if (i == 0) begin
        check("first_valid", {31'b0, tx_valid}, 32'd1);
        check("first_data", {24'b0, tx_data}, 32'h41);
      end
    end
    access(0, A_ST, C_W, 0, rd);
    check("status_ovf", rd, 32'h6);
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) drain_check($sformatf("drain1_%0d", i), 8'h41 + 8'(i));
    tx_ready = 1'b0;
    check("drain1_empty", {31'b0, tx_valid}, 32'd0);
    check("drain1_data0", {24'b0, tx_data}, 32'd0);
    access(0, A_ST, C_W, 0, rd);
    check("status_drained", rd, 32'h5);
    access(1, A_ST, C_W, 32'h4, rd);
    access(0, A_ST, C_W, 0, rd);
    check("status_oclr", rd, 32'h1);

    // Full FIFO, pop and push in the same cycle
    for (int i = 0; i < 8; i++) access(1, A_TX, C_W, 32'h61 + i, rd);
    access(0, A_ST, C_W, 0, rd);
    check("status_full", rd, 32'h2);
    tx_ready = 1'b1;
    access(1, A_TX, C_W, 32'h5A, rd);
    tx_ready = 1'b0;
    access(0, A_ST, C_W, 0, rd);
    check("status_pushpop", rd, 32'h2);
    tx_ready = 1'b1;
    for (int i = 0; i < 7; i++) drain_check($sformatf("drain2_%0d", i), 8'h62 + 8'(i));
    drain_check("drain2_last", 8'h5A);
    tx_ready = 1'b0;
    check("drain2_empty", {31'b0, tx_valid}, 32'd0);

    // Reset in the middle of a drain
    access(1, A_TX, C_W, 32'h77, rd);
    access(1, A_TX, C_W, 32'h78, rd);
    tx_ready = 1'b1;
    idle(1);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    tx_ready = 1'b0;
    check("mid_rst_valid", {31'b0, tx_valid}, 32'd0);
    check("mid_rst_data", {24'b0, tx_data}, 32'd0);
    access(0, A_CLO, C_W, 0, rd);
    check("mid_rst_cnt", rd, 32'd0);
    access(0, A_ST, C_W, 0, rd);
    check("mid_rst_status", rd, 32'h1);

    // Counter: second read 11 cycles after the first
    access(0, A_CLO, C_W, 0, c1);
    check("cnt_v1", c1, 32'd2);
    idle(10);
    access(0, A_CLO, C_W, 0, c2);
    check("cnt_delta", c2 - c1, 32'd11);
    access(0, A_CHI, C_W, 0, rd);
    check("cnt_hi", rd, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
